smooth_window_ctrl: RTL and testbench



---
 rtl/smooth_window_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_smooth_window_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smooth_window_ctrl.sv
// Raster-scan 3x3 window sequencer for the smoothing datapath.
// Optional frame counter output: define SMOOTH_WINDOW_CTRL_FRAME_CNT_EN.
module smooth_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PIX_W-1:0]           pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [9*PIX_W-1:0]         win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       busy,
`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
  output logic [15:0]                frame_cnt,
`endif
  output logic                       done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;

  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];

  // Column c-2 and column c-1 of the three most recent lines.
  logic [PIX_W-1:0] cold_q [3];
  logic [PIX_W-1:0] cnew_q [3];
  logic [PIX_W-1:0] col_in [3];

  logic [9*PIX_W-1:0] win_data_q, win_data_d;
  logic [RW-1:0]      win_row_q, win_row_d;
  logic [CW-1:0]      win_col_q, win_col_d;
  logic               win_valid_q, win_valid_d;
  logic               busy_q;
  logic               done_q, done_d;

  logic accept;
  logic emit;
  logic last_col;
  logic last_pix;

  assign in_ready = (state_q == STREAM) &&
                    (!win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (r_q >= RW'(2)) &&
                    (c_q >= CW'(2));
  assign last_col = (c_q == CW'(IMG_W - 1));
  assign last_pix = last_col && (r_q == RW'(IMG_H - 1));

  assign col_in[0] = lb_b[c_q];
  assign col_in[1] = lb_a[c_q];
  assign col_in[2] = pixel_in;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          r_d     = '0;
          c_d     = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (last_col) begin
            c_d = '0;
            r_d = last_pix ? '0 : r_q + RW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
          if (last_pix) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!win_valid_q || win_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = r_q - RW'(1);
      win_col_d   = c_q - CW'(1);
      for (int dy = 0; dy < 3; dy++) begin
        win_data_d[(3*dy+0)*PIX_W +: PIX_W] = cold_q[dy];
        win_data_d[(3*dy+1)*PIX_W +: PIX_W] = cnew_q[dy];
        win_data_d[(3*dy+2)*PIX_W +: PIX_W] = col_in[dy];
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cold_q[i] <= '0;
        cnew_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          cold_q[i] <= cnew_q[i];
          cnew_q[i] <= col_in[i];
        end
      end
    end
  end

  // Line RAM carries no reset; rows 0-1 never emit, so stale data is masked.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[c_q] <= lb_a[c_q];
      lb_a[c_q] <= pixel_in;
    end
  end

`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_valid = win_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_smooth_window_ctrl.sv
// Directed bench for smooth_window_ctrl: 4x4 scenarios plus a
// randomised 64x64 frame checked against a stored reference image.
module tb_smooth_window_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, in_valid, win_ready, in_ready;
  logic [7:0]  pixel_in;
  logic [71:0] win_data;
  logic [1:0]  win_row, win_col;
  logic        win_valid, busy, done;

  logic        b_start, b_in_valid, b_win_ready, b_in_ready;
  logic [7:0]  b_pixel_in;
  logic [71:0] b_win_data;
  logic [5:0]  b_win_row, b_win_col;
  logic        b_win_valid, b_busy, b_done;

`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt, b_frame_cnt;
`endif

  smooth_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy),
`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .done(done)
  );

  smooth_window_ctrl u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .pixel_in(b_pixel_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready),
    .win_data(b_win_data), .win_row(b_win_row),
    .win_col(b_win_col),
    .win_valid(b_win_valid), .win_ready(b_win_ready),
    .busy(b_busy),
`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
    .frame_cnt(b_frame_cnt),
`endif
    .done(b_done)
  );

  int checks = 0;
  int failures = 0;

  logic [71:0] rec_d [16];
  int          rec_r [16];
  int          rec_c [16];
  int nwin, ndone, nacc, first_acc, last_acc, last_hs, done_cyc;
  bit busy_at_done;
  int stall_seen;

  logic [7:0] fr [4096];

  function automatic logic [71:0] exp_win(input int rr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[(3*dy+dx)*8 +: 8] = 8'(16*(rr-1+dy) + (cc-1+dx));
    return w;
  endfunction

  function automatic logic [71:0] big_win(input int rr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[(3*dy+dx)*8 +: 8] = fr[64*(rr-1+dy) + (cc-1+dx)];
    return w;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one 4x4 frame (pixel = 16*r+c) and records what comes out.
  task automatic run_frame(input int ivmode, input bit stall,
                           input bit start_mid, input int max_acc);
    int p;
    int stall_left;
    bit stall_used;
    logic [71:0] hold_d;
    logic [1:0]  hold_r, hold_c;
    p = 0; stall_left = 0; stall_used = 0;
    hold_d = '0; hold_r = '0; hold_c = '0;
    nwin = 0; ndone = 0; nacc = 0; first_acc = -1; last_acc = -1;
    last_hs = -1; done_cyc = -1; busy_at_done = 1'b1; stall_seen = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (stall && !stall_used && win_valid) begin
        stall_used = 1;
        stall_left = 5;
        hold_d = win_data; hold_r = win_row; hold_c = win_col;
      end
      start     = start_mid && (cyc == 4);
      in_valid  = (p < max_acc) && (ivmode == 0 || cyc % 2 == 0);
      pixel_in  = 8'(16*(p/4) + p%4);
      win_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        stall_seen++;
        checks++;
        if (in_ready !== 1'b0 || win_data !== hold_d ||
            win_row !== hold_r || win_col !== hold_c) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d in_ready=%b data=%h/%0d/%0d want 0 %h/%0d/%0d",
                   cyc, in_ready, win_data, win_row, win_col,
                   hold_d, hold_r, hold_c);
        end
        stall_left--;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (win_valid && win_ready) begin
        if (nwin < 16) begin
          rec_d[nwin] = win_data;
          rec_r[nwin] = int'(win_row);
          rec_c[nwin] = int'(win_col);
        end
        nwin++;
        last_hs = cyc;
      end
      if (in_valid && in_ready) begin
        if (nacc == 0) first_acc = cyc;
        last_acc = cyc;
        nacc++;
        p++;
        if (p == max_acc && max_acc < 16) break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; in_valid = 0; win_ready = 0; pixel_in = '0;
    b_start = 0; b_in_valid = 0; b_win_ready = 0; b_pixel_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, win_valid, busy, done} !== 4'b0 ||
        win_data !== '0 || win_row !== '0 || win_col !== '0) begin
      failures++;
      $display("FAIL reset_state rdy/vld/busy/done=%b data=%h row=%0d col=%0d want all 0",
               {in_ready, win_valid, busy, done}, win_data, win_row, win_col);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got %b want 1", busy);
    end
    run_frame(0, 0, 0, 16);
    checks++;
    if (nwin !== 4) begin
      failures++;
      $display("FAIL basic_count got %0d want 4", nwin);
    end
    checks++;
    if (rec_d[0] !== 72'h22_21_20_12_11_10_02_01_00 ||
        rec_r[0] !== 1 || rec_c[0] !== 1) begin
      failures++;
      $display("FAIL basic_first got %h (%0d,%0d) want 222120121110020100 (1,1)",
               rec_d[0], rec_r[0], rec_c[0]);
    end
    checks++;
    if (rec_d[3] !== 72'h33_32_31_23_22_21_13_12_11 ||
        rec_r[3] !== 2 || rec_c[3] !== 2) begin
      failures++;
      $display("FAIL basic_last got %h (%0d,%0d) want 333231232221131211 (2,2)",
               rec_d[3], rec_r[3], rec_c[3]);
    end
    checks++;
    if (nacc !== 16 || last_acc - first_acc !== 15) begin
      failures++;
      $display("FAIL basic_rate accepts=%0d span=%0d want 16 15",
               nacc, last_acc - first_acc);
    end
    checks++;
    if (ndone !== 1 || done_cyc !== last_hs + 1 || busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done pulses=%0d at=%0d busy=%b want 1 at %0d busy 0",
               ndone, done_cyc, busy_at_done, last_hs + 1);
    end
  endtask

  task automatic test_backpressure();
    do_start();
    run_frame(0, 1, 0, 16);
    checks++;
    if (stall_seen !== 5) begin
      failures++;
      $display("FAIL stall_cycles got %0d want 5", stall_seen);
    end
    checks++;
    if (nwin !== 4 || ndone !== 1) begin
      failures++;
      $display("FAIL stall_count windows=%0d done=%0d want 4 1", nwin, ndone);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rec_d[i] !== exp_win(1 + i/2, 1 + i%2) ||
          rec_r[i] !== 1 + i/2 || rec_c[i] !== 1 + i%2) begin
        failures++;
        $display("FAIL stall_win%0d got %h (%0d,%0d) want %h (%0d,%0d)",
                 i, rec_d[i], rec_r[i], rec_c[i],
                 exp_win(1 + i/2, 1 + i%2), 1 + i/2, 1 + i%2);
      end
    end
  endtask

  task automatic test_toggle_valid();
    do_start();
    run_frame(1, 0, 0, 16);
    checks++;
    if (nwin !== 4 || ndone !== 1 || nacc !== 16) begin
      failures++;
      $display("FAIL toggle_count windows=%0d done=%0d acc=%0d want 4 1 16",
               nwin, ndone, nacc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rec_d[i] !== exp_win(1 + i/2, 1 + i%2) ||
          rec_r[i] !== 1 + i/2 || rec_c[i] !== 1 + i%2) begin
        failures++;
        $display("FAIL toggle_win%0d got %h (%0d,%0d) want %h (%0d,%0d)",
                 i, rec_d[i], rec_r[i], rec_c[i],
                 exp_win(1 + i/2, 1 + i%2), 1 + i/2, 1 + i%2);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    run_frame(0, 0, 0, 7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (nacc !== 7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL prereset accepts=%0d busy=%b want 7 1", nacc, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, win_valid, busy, done} !== 4'b0 ||
        win_data !== '0 || win_row !== '0 || win_col !== '0) begin
      failures++;
      $display("FAIL async_reset rdy/vld/busy/done=%b data=%h row=%0d col=%0d want all 0",
               {in_ready, win_valid, busy, done}, win_data, win_row, win_col);
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abort_done got %0d want 0", ndone);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    run_frame(0, 0, 0, 16);
    checks++;
    if (nwin !== 4 || rec_d[0] !== exp_win(1, 1) ||
        rec_r[0] !== 1 || rec_c[0] !== 1) begin
      failures++;
      $display("FAIL post_reset_first n=%0d got %h (%0d,%0d) want 4 %h (1,1)",
               nwin, rec_d[0], rec_r[0], rec_c[0], exp_win(1, 1));
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    run_frame(0, 0, 1, 16);
    checks++;
    if (nwin !== 4 || ndone !== 1) begin
      failures++;
      $display("FAIL start_mid windows=%0d done=%0d want 4 1", nwin, ndone);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_frame busy=%b want 0", busy);
    end
    do_start();
    run_frame(0, 0, 0, 16);
    checks++;
    if (nwin !== 4 || ndone !== 1 || rec_d[3] !== exp_win(2, 2)) begin
      failures++;
      $display("FAIL second_frame windows=%0d done=%0d last=%h want 4 1 %h",
               nwin, ndone, rec_d[3], exp_win(2, 2));
    end
`ifdef SMOOTH_WINDOW_CTRL_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL frame_cnt got %0d want 2", frame_cnt);
    end
`endif
  endtask

  task automatic test_random_64();
    int p, n, bad, er, ec;
    bit seen_done;
    p = 0; n = 0; bad = 0; seen_done = 0;
    for (int i = 0; i < 4096; i++) fr[i] = 8'($urandom);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      b_in_valid  = (p < 4096) && ($urandom_range(0, 3) != 0);
      b_pixel_in  = (p < 4096) ? fr[p] : 8'h00;
      b_win_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (b_done) begin
        seen_done = 1;
        break;
      end
      if (b_win_valid && b_win_ready) begin
        er = 1 + n / 62;
        ec = 1 + n % 62;
        checks++;
        if (int'(b_win_row) !== er || int'(b_win_col) !== ec ||
            b_win_data !== big_win(er, ec)) begin
          failures++;
          bad++;
          if (bad < 5)
            $display("FAIL rand_win%0d got %h (%0d,%0d) want %h (%0d,%0d)",
                     n, b_win_data, b_win_row, b_win_col,
                     big_win(er, ec), er, ec);
        end
        n++;
      end
      if (b_in_valid && b_in_ready) p++;
    end
    b_in_valid = 1'b0;
    checks++;
    if (!seen_done || n !== 3844 || p !== 4096) begin
      failures++;
      $display("FAIL rand_count done=%0d windows=%0d accepts=%0d want 1 3844 4096",
               seen_done, n, p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle_valid();
    test_reset_mid_frame();
    test_start_ignored();
    test_random_64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
